// File: rtl/uart_prog_loader_if.sv
// rtl/uart_prog_loader_if.sv - instruction-memory write port bundle for the UART program loader
interface uart_prog_loader_if #(
  parameter int ADDR_W = 8
);
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;

  modport master (
    output imem_we,
    output imem_addr,
    output imem_data
  );

  modport slave (
    input imem_we,
    input imem_addr,
    input imem_data
  );
endinterface

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - UART 8N1 receiver and image loader that fills instruction memory and gates CPU reset
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rxd,
  uart_prog_loader_if.master  imem,
  output logic                cpu_rst_n,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int              CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]   FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_M1 = CW'((CLKS_PER_BIT / 2 > 0) ? (CLKS_PER_BIT / 2 - 1) : 0);
  localparam int              WCW     = ADDR_W + 1;
  localparam logic [7:0]      HDR     = 8'hA5;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [2:0] {L_HDR, L_CNT, L_DATA, L_SUM, L_DONE, L_ERR} ld_state_t;

  logic              rxd_s1, rxd_s2, rxd_d;
  logic              rx_fall;
  rx_state_t         rx_state, rx_next;
  logic [CW-1:0]     rx_cnt;
  logic [2:0]        rx_bit;
  logic [7:0]        rx_shift;
  logic              rx_tick;
  logic              byte_valid;
  logic              frame_err;

  ld_state_t         ld_state, ld_next;
  logic [1:0]        byte_idx;
  logic [WCW-1:0]    words_left;
  logic [7:0]        csum;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       data_q;
  logic              last_byte, last_word;

  // Two-flop synchronizer plus one delay stage for start-bit edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
      rxd_d  <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
      rxd_d  <= rxd_s2;
    end
  end

  assign rx_fall = rxd_d & ~rxd_s2;

  // Receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_state <= R_IDLE;
    else        rx_state <= rx_next;
  end

  // Receiver next state, sample ticks and byte/frame-error pulses
  always_comb begin
    rx_next    = rx_state;
    rx_tick    = 1'b0;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state)
      R_IDLE:  if (rx_fall) rx_next = R_START;
      R_START: if (rx_cnt == HALF_M1) begin
                 rx_tick = 1'b1;
                 rx_next = rxd_s2 ? R_IDLE : R_DATA;
               end
      R_DATA:  if (rx_cnt == FULL_M1) begin
                 rx_tick = 1'b1;
                 if (rx_bit == 3'd7) rx_next = R_STOP;
               end
      R_STOP:  if (rx_cnt == FULL_M1) begin
                 rx_tick = 1'b1;
                 rx_next = R_IDLE;
                 if (rxd_s2) byte_valid = 1'b1;
                 else        frame_err  = 1'b1;
               end
      default: rx_next = R_IDLE;
    endcase
  end

  // Bit timer, bit index and LSB-first shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      if (rx_state == R_IDLE || rx_tick) rx_cnt <= '0;
      else                               rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == R_DATA && rx_tick) begin
        rx_shift <= {rxd_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 1'b1;
      end else if (rx_state != R_DATA) begin
        rx_bit <= '0;
      end
    end
  end

  assign last_byte = (byte_idx == 2'd3);
  assign last_word = (words_left == WCW'(1));

  // Loader state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ld_state <= L_HDR;
    else        ld_state <= ld_next;
  end

  // Loader next state; a frame error mid-image always wins
  always_comb begin
    ld_next = ld_state;
    case (ld_state)
      L_HDR:   if (byte_valid && rx_shift == HDR) ld_next = L_CNT;
      L_CNT:   if (frame_err) ld_next = L_ERR;
               else if (byte_valid) ld_next = L_DATA;
      L_DATA:  if (frame_err) ld_next = L_ERR;
               else if (byte_valid && last_byte && last_word) ld_next = L_SUM;
      L_SUM:   if (frame_err) ld_next = L_ERR;
               else if (byte_valid) ld_next = (rx_shift == csum) ? L_DONE : L_ERR;
      L_DONE,
      L_ERR:   if (byte_valid && rx_shift == HDR) ld_next = L_CNT;
      default: ld_next = L_HDR;
    endcase
  end

  // Word assembly, checksum, write strobe and address/word-count bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      csum       <= '0;
      byte_idx   <= '0;
      words_left <= '0;
    end else begin
      we_q <= (ld_state == L_DATA) && byte_valid && last_byte;
      if (ld_state == L_CNT && byte_valid) begin
        words_left <= (rx_shift == 8'd0) ? WCW'(1 << ADDR_W) : WCW'(rx_shift);
        addr_q     <= '0;
        csum       <= '0;
        byte_idx   <= '0;
      end else if (ld_state == L_DATA && byte_valid) begin
        data_q   <= {data_q[23:0], rx_shift};
        csum     <= csum ^ rx_shift;
        byte_idx <= byte_idx + 1'b1;
      end
      if (we_q) begin
        addr_q     <= addr_q + 1'b1;
        words_left <= words_left - 1'b1;
      end
    end
  end

  // Status outputs registered from the next loader state so they are glitch-free
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cpu_rst_n <= (ld_next == L_DONE);
      done      <= (ld_next == L_DONE);
      err       <= (ld_next == L_ERR);
      busy      <= (ld_next == L_CNT) || (ld_next == L_DATA) || (ld_next == L_SUM);
    end
  end

  assign imem.imem_we   = we_q;
  assign imem.imem_addr = addr_q;
  assign imem.imem_data = data_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - directed self-checking bench for uart_prog_loader
module tb_uart_prog_loader;
  localparam int CPB = 8;
  localparam int AW  = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rxd   = 1'b1;
  logic cpu_rst_n, busy, done, err;

  uart_prog_loader_if #(.ADDR_W(AW)) imem ();

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .imem      (imem),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [AW+31:0] exp_q[$];
  logic [AW+31:0] exp_e;
  logic           exp_done;
  logic [7:0]     img[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next write the image model predicts
  always @(negedge clk) begin
    if (rst_n && imem.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_we: got write addr 0x%0h data 0x%0h, expected none", imem.imem_addr, imem.imem_data);
      end else begin
        exp_e = exp_q.pop_front();
        chk("we_addr", 32'(imem.imem_addr), 32'(exp_e[AW+31:32]));
        chk("we_data", imem.imem_data, exp_e[31:0]);
      end
    end
  end

  // Image-level model: skip to header, then N words MSB first, then an XOR checksum
  task automatic model_image(input logic [7:0] b[$]);
    int         k;
    int         n;
    logic [7:0] x;
    logic [31:0] w;
    k = 0;
    x = 8'h00;
    while (k < b.size() && b[k] != 8'hA5) k++;
    n = (b[k+1] == 8'h00) ? (1 << AW) : int'(b[k+1]);
    for (int i = 0; i < n; i++) begin
      w = {b[k+2+4*i], b[k+3+4*i], b[k+4+4*i], b[k+5+4*i]};
      x = x ^ b[k+2+4*i] ^ b[k+3+4*i] ^ b[k+4+4*i] ^ b[k+5+4*i];
      exp_q.push_back({AW'(i), w});
    end
    exp_done = (b[k+2+4*n] == x);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_cyc(CPB);
    end
    rxd = stop;
    wait_cyc(CPB);
    rxd = 1'b1;
  endtask

  task automatic send_list(input logic [7:0] b[$]);
    foreach (b[i]) send_byte(b[i], 1'b1);
  endtask

  task automatic check_flags(input string name);
    wait_cyc(3);
    @(negedge clk);
    chk({name, "_done"}, 32'(done), 32'(exp_done));
    chk({name, "_err"}, 32'(err), 32'(!exp_done));
    chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(exp_done));
    chk({name, "_busy"}, 32'(busy), 32'(0));
    chk({name, "_writes_left"}, 32'(exp_q.size()), 32'(0));
  endtask

  task automatic run_image(input string name, input logic [7:0] b[$]);
    model_image(b);
    send_list(b);
    check_flags(name);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_we"}, 32'(imem.imem_we), 32'(0));
    chk({name, "_addr"}, 32'(imem.imem_addr), 32'(0));
    chk({name, "_data"}, imem.imem_data, 32'(0));
    chk({name, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(0));
    chk({name, "_busy"}, 32'(busy), 32'(0));
    chk({name, "_done"}, 32'(done), 32'(0));
    chk({name, "_err"}, 32'(err), 32'(0));
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(3);
    @(negedge clk);
    check_reset_outputs("reset");

    // Single word
    img = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_image("single", img);
    chk("single_data_literal", imem.imem_data, 32'h12345678);
    chk("single_addr_literal", 32'(imem.imem_addr), 32'd1);
    chk("single_done_literal", 32'(done), 32'd1);

    // Three words, checksum 01^02^03 = 00
    img = '{8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
            8'h00, 8'h00, 8'h00, 8'h03, 8'h00};
    run_image("multi", img);
    chk("multi_addr_literal", 32'(imem.imem_addr), 32'd3);

    // Bad checksum: write still happens
    img = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF};
    run_image("badsum", img);
    chk("badsum_err_literal", 32'(err), 32'd1);

    // Framing error on the 2nd data byte
    send_byte(8'hA5, 1'b1);
    wait_cyc(2);
    chk("ferr_reload_err", 32'(err), 32'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    wait_cyc(3);
    @(negedge clk);
    chk("ferr_err", 32'(err), 32'd1);
    chk("ferr_done", 32'(done), 32'd0);
    chk("ferr_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("ferr_busy", 32'(busy), 32'd0);
    img = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    run_image("ferr_recover", img);

    // Noise: fresh reset, non-header bytes, then a glitch right after the header
    rst_n = 1'b0;
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);
    send_list('{8'h00, 8'hFF, 8'h5A});
    wait_cyc(2);
    chk("noise_pre_busy", 32'(busy), 32'd0);
    chk("noise_pre_done", 32'(done), 32'd0);
    img = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
            8'h00, 8'h00, 8'h00, 8'h01, 8'h23};
    model_image(img);
    send_byte(8'hA5, 1'b1);
    wait_cyc(10);
    rxd = 1'b0;
    wait_cyc(3);
    rxd = 1'b1;
    wait_cyc(20);
    send_list('{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h01, 8'h23});
    check_flags("noise");
    chk("noise_done_literal", 32'(done), 32'd1);

    // Reload while done
    img = '{8'hA5, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    model_image(img);
    chk("reload_pre_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    chk("reload_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    chk("reload_done", 32'(done), 32'd0);
    send_byte(8'h01, 1'b1);
    @(negedge clk);
    chk("reload_busy", 32'(busy), 32'd1);
    send_list('{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00});
    check_flags("reload");

    // Reset after 2 of 4 words
    exp_q.push_back({8'd0, 32'h11111111});
    exp_q.push_back({8'd1, 32'h22222222});
    send_list('{8'hA5, 8'h04, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22});
    wait_cyc(4);
    @(negedge clk);
    chk("midload_writes_left", 32'(exp_q.size()), 32'd0);
    chk("midload_addr", 32'(imem.imem_addr), 32'd2);
    chk("midload_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midload_reset");
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(2);
    img = '{8'hA5, 8'h01, 8'h0B, 8'hAD, 8'hF0, 8'h0D, 8'h5B};
    run_image("fresh", img);
    chk("fresh_addr_literal", 32'(imem.imem_addr), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial boot loader that sits directly upstream of the single-cycle CPU core. It receives a program image over a UART line and writes it word by word into the CPU's instruction memory. It holds the core in reset while loading and releases it only after a valid image with a correct checksum. It replaces the fixed ROM image as the source of instructions at address 0 onward.

## Interface

Parameters:
- CLKS_PER_BIT, default 434: clk cycles per UART bit (50 MHz / 115200).
- ADDR_W, default 8: instruction-memory address width; matches the 8-bit PC.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rxd  in  1  UART receive line, 8N1, idle high, asynchronous to clk.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_W  word address for the write.
- imem_data  out  32  instruction word for the write.
- cpu_rst_n  out  1  reset to the CPU core, active-low; 0 holds the core.
- busy  out  1  high while a load is in progress.
- done  out  1  high after a successful load.
- err  out  1  high after a framing or checksum failure.

## Operation

- rxd passes through a 2-flop synchronizer; every receiver decision uses the synchronized value.
- Receiver FSM, states R_IDLE, R_START, R_DATA, R_STOP:
  - R_IDLE: a falling edge on the line moves to R_START.
  - R_START: waits CLKS_PER_BIT/2 cycles (integer divide), then samples. Low continues to R_DATA; high is a glitch and returns to R_IDLE.
  - R_DATA: samples 8 bits, LSB first, one every CLKS_PER_BIT cycles.
  - R_STOP: samples once after CLKS_PER_BIT cycles. High raises internal byte_valid for 1 cycle; low raises frame_err for 1 cycle. Both paths return to R_IDLE.
- Loader FSM, states L_HDR, L_CNT, L_DATA, L_SUM, L_DONE, L_ERR:
  - L_HDR: byte 0xA5 moves to L_CNT. Any other byte is ignored.
  - L_CNT: the byte is the word count N; 0 means 2^ADDR_W words. Loads the word counter, clears imem_addr and the checksum, sets busy, drives cpu_rst_n=0 and done=0. Moves to L_DATA.
  - L_DATA: bytes arrive MSB first and shift into imem_data. After every 4th byte, imem_we pulses, then imem_addr increments and the word counter decrements. When the last word is written, moves to L_SUM.
  - L_SUM: the byte must equal the XOR of all data bytes. Match goes to L_DONE; mismatch goes to L_ERR.
  - L_DONE: done=1, cpu_rst_n=1, busy=0.
  - L_ERR: err=1, cpu_rst_n=0, busy=0.
- Both L_DONE and L_ERR stay until a byte 0xA5 arrives. That byte moves to L_CNT, clears done and err, and drives cpu_rst_n=0 immediately. This is a reload.
- frame_err in L_CNT, L_DATA or L_SUM goes to L_ERR. In L_HDR, L_DONE and L_ERR, frame_err is ignored.
- The header and count bytes are not part of the checksum.
- imem_addr wraps modulo 2^ADDR_W. With N=0 all 2^ADDR_W words are written and imem_addr ends at 0.

## Timing

- Reset values: imem_we=0, imem_addr=0, imem_data=0, cpu_rst_n=0, busy=0, done=0, err=0. Receiver is in R_IDLE, loader in L_HDR.
- Synchronizer latency is 2 cycles.
- byte_valid occurs about 9.5×CLKS_PER_BIT + 2 cycles after the start-bit falling edge.
- imem_we asserts in the cycle after the byte_valid of the 4th byte of a word. imem_addr and imem_data are stable during that cycle.
- imem_addr updates in the cycle after imem_we.
- cpu_rst_n, done and err change in the cycle after the byte_valid of the deciding byte. The deciding byte is the checksum byte, or the header byte on a reload.
- A frame_err in the same cycle as a state-driven transition takes priority and goes to L_ERR.
- rst_n asserted mid-load returns every output to its reset value at once. Memory contents already written are kept.
- At most one byte event per cycle. Back-to-back frames with a single stop bit must be received without loss.

## Test plan

Benches use CLKS_PER_BIT=8.

- Single word: send A5 01 12 34 56 78 08 → one imem_we with addr 0, data 0x12345678; then done=1, cpu_rst_n=1, err=0.
- Multiple words: send A5 03, then words 0x00000001, 0x00000002, 0x00000003, then checksum 00 → writes at addr 0, 1, 2; imem_addr=3 at the end; done=1.
- Bad checksum: send A5 01 12 34 56 78 FF → the write still occurs; err=1, cpu_rst_n=0, done=0.
- Framing error: a stop bit of 0 during the 2nd data byte → err=1 and no imem_we pulse. A following valid image clears err and sets done.
- Noise and reload:
  - A 3-cycle low glitch on rxd in idle → no byte is received.
  - Non-A5 bytes before the header → ignored.
  - A5 sent while in L_DONE → cpu_rst_n drops to 0 the cycle after that byte_valid.
- Reset mid-load: rst_n pulsed low after 2 of 4 words → all outputs return to reset values. A fresh image then loads starting at addr 0.
